pulse_checker: RTL



---
 rtl/pulse_checker_if.sv | 31 +++
 rtl/pulse_checker.sv | 103 ++++++++++
 2 files changed

// File: rtl/pulse_checker_if.sv
// ============================================================================
//  Module   : pulse_checker_if
//  Brief    : Serial pulse line and checker result bundle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_checker_if #(
   parameter int CNT_W = 8
);
   logic             y_in;
   logic             pulse_ok;
   logic             err_width;
   logic             err_gap;
   logic             err_flag;
   logic [CNT_W-1:0] count;

   // Pulse source / result consumer side
   modport master (
      output y_in,
      input  pulse_ok, err_width, err_gap, err_flag, count
   );

   // Checker side
   modport slave (
      input  y_in,
      output pulse_ok, err_width, err_gap, err_flag, count
   );
endinterface

`default_nettype wire

// File: rtl/pulse_checker.sv
// ============================================================================
//  Module   : pulse_checker
//  Brief    : Checks each pulse on y_in is one cycle wide with >= GUARD lows.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_checker #(
   parameter int GUARD = 5,
   parameter int CNT_W = 8
) (
   input  wire logic          clk,
   input  wire logic          reset,
   pulse_checker_if.slave     bus
);
   localparam int ZC_W = $clog2(GUARD + 1);
   localparam logic [ZC_W-1:0] c_guard = ZC_W'(GUARD);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HIGH  = 2'd1,
      S_GUARD = 2'd2,
      S_WIDE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [ZC_W-1:0]  r_zc;
   logic [CNT_W-1:0] r_count;
   logic             r_pulse_ok;
   logic             r_err_width;
   logic             r_err_gap;
   logic             r_err_flag;

   logic [ZC_W-1:0]  w_zc_inc;
   logic [CNT_W-1:0] w_count_next;

   assign w_zc_inc     = r_zc + 1'b1;
   // Counter holds at all-ones rather than wrapping
   assign w_count_next = (r_count == '1) ? r_count : r_count + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_zc        <= '0;
         r_count     <= '0;
         r_pulse_ok  <= 1'b0;
         r_err_width <= 1'b0;
         r_err_gap   <= 1'b0;
         r_err_flag  <= 1'b0;
      end else begin
         r_pulse_ok  <= 1'b0;
         r_err_width <= 1'b0;
         r_err_gap   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.y_in) r_state <= S_HIGH;
            end
            S_HIGH: begin
               if (bus.y_in) begin
                  r_state     <= S_WIDE;
                  r_err_width <= 1'b1;
                  r_err_flag  <= 1'b1;
               end else if (GUARD == 1) begin
                  // A single low sample already satisfies a one-cycle guard
                  r_state    <= S_IDLE;
                  r_pulse_ok <= 1'b1;
                  r_count    <= w_count_next;
               end else begin
                  r_state <= S_GUARD;
                  r_zc    <= ZC_W'(1);
               end
            end
            S_GUARD: begin
               if (bus.y_in) begin
                  r_state    <= S_HIGH;
                  r_err_gap  <= 1'b1;
                  r_err_flag <= 1'b1;
               end else if (w_zc_inc == c_guard) begin
                  r_state    <= S_IDLE;
                  r_pulse_ok <= 1'b1;
                  r_count    <= w_count_next;
               end else begin
                  r_zc <= w_zc_inc;
               end
            end
            S_WIDE: begin
               // Gap after a wide pulse is deliberately not checked
               if (!bus.y_in) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.pulse_ok  = r_pulse_ok;
   assign bus.err_width = r_err_width;
   assign bus.err_gap   = r_err_gap;
   assign bus.err_flag  = r_err_flag;
   assign bus.count     = r_count;

endmodule

`default_nettype wire
